vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Generates the VGA timing that the pong game logic consumes: active-low hsync/vsync pulses, plus matching column/row counters, an active-video flag and a frame-start strobe.
- Acts as the transmitting end of the sync interface; the game logic receives these signals and forwards them, re-timed, to the DAC pins.
- Defaults give 640x480 at 60 Hz from a 25 MHz pixel clock.

Parameters:
TOTAL_COLS, 800, pixels per line including blanking
TOTAL_ROWS, 525, lines per frame including blanking
ACTIVE_COLS, 640, visible pixels per line
ACTIVE_ROWS, 480, visible lines per frame
H_FRONT_PORCH, 16, pixels between end of active video and start of hsync
H_SYNC_WIDTH, 96, hsync low width in pixels
V_FRONT_PORCH, 10, lines between end of active video and start of vsync
V_SYNC_WIDTH, 2, vsync low width in lines
SYNC_DELAY, 2, extra pipeline stages on hsync/vsync (only with VGA_SYNC_DELAY_EN)

Ports:
clk  in  1  pixel-domain clock
i_rst_n  in  1  asynchronous active-low reset
i_pix_en  in  1  pixel strobe; timing advances only when high (tie high for 25 MHz clk)
o_hsync  out  1  horizontal sync, active low
o_vsync  out  1  vertical sync, active low
o_col  out  CW=$clog2(TOTAL_COLS)  current column, 0..TOTAL_COLS-1
o_row  out  RW=$clog2(TOTAL_ROWS)  current row, 0..TOTAL_ROWS-1
o_active  out  1  high when o_col<ACTIVE_COLS and o_row<ACTIVE_ROWS
o_frame_start  out  1  one-cycle pulse when position becomes (0,0)

Behaviour:
- Reset is asynchronous on i_rst_n low: o_col=0, o_row=0, o_hsync=1, o_vsync=1, o_active=0, o_frame_start=0. All delay-pipe stages are reset to 1.
- Timing advances on a clk rising edge with i_pix_en=1. With i_pix_en=0, every output holds its value, except o_frame_start, which is forced to 0.
- Column advances by 1 each step. At TOTAL_COLS-1 it wraps to 0 and the row advances.
- Row wraps from TOTAL_ROWS-1 to 0 only on a column wrap.
- All outputs are registered and describe the same position (o_col,o_row) in the same cycle. Flags are computed from the next-state counter values.
- o_hsync=0 iff ACTIVE_COLS+H_FRONT_PORCH <= col < ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH. Defaults: cols 656..751.
- o_vsync=0 iff ACTIVE_ROWS+V_FRONT_PORCH <= row < ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH. Defaults: rows 490..491, all columns.
- o_active is high for col 0..639 and row 0..479.
- o_frame_start=1 for exactly one enabled step: the step whose next position is (0,0), i.e. the wrap from (799,524).
- The first post-reset position (0,0) is held without a pulse. The first o_frame_start occurs at the end of frame 0.
- Counters never exceed TOTAL-1. Comparisons are done at full counter width, with no truncation.
- Release of reset mid-frame restarts the frame at (0,0). There is no partial-frame recovery.
- Elaboration check: ACTIVE+FRONT_PORCH+SYNC_WIDTH <= TOTAL on both axes, otherwise $error.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN.
- When defined:
  - o_hsync and o_vsync pass through a SYNC_DELAY-stage shift register clocked on enabled steps.
  - The sync outputs lag o_col/o_row/o_active by SYNC_DELAY pixels, matching the game pixel pipeline.
  - o_active and o_frame_start are not delayed.
- When undefined: no delay registers exist and the syncs align with the counters as above.

Test Plan:
- Assert i_rst_n=0 mid-line, then release -> outputs are immediately 0/0/1/1/0/0 while reset is held; after release, o_col counts 0,1,2,...
- i_pix_en=1 for one full line -> o_hsync low exactly at o_col 656..751 (96 cycles); o_active low for cols 640..799; o_row increments once at the 799->0 wrap.
- Run 2 full frames -> o_vsync low for exactly 2*800 cycles, at rows 490..491; o_frame_start pulses exactly once per 420000 cycles, in the cycle where (o_col,o_row)=(0,0).
- Toggle i_pix_en 1,0,1,0 -> counters advance every second cycle; line period becomes 1600 clocks; o_frame_start never lasts more than 1 cycle.
- Override TOTAL_COLS=10, ACTIVE_COLS=6, H_FRONT_PORCH=1, H_SYNC_WIDTH=2 -> o_hsync low at cols 7..8; column wraps 9->0.
- With VGA_SYNC_DELAY_EN and SYNC_DELAY=2 -> first hsync fall occurs when o_col=658; the pulse is still 96 cycles wide.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA sync generator: column/row counters, active-low syncs, active flag, frame strobe.
// Optional macro VGA_SYNC_DELAY_EN delays hsync/vsync by SYNC_DELAY enabled steps.
module vga_sync_gen #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2,
  parameter int SYNC_DELAY    = 2,
  localparam int CW = $clog2(TOTAL_COLS),
  localparam int RW = $clog2(TOTAL_ROWS)
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_pix_en,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_active,
  output logic          o_frame_start
);

  // One spare bit so sync end values equal to TOTAL still compare correctly.
  localparam logic [CW-1:0] COL_MAX = CW'(TOTAL_COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(TOTAL_ROWS - 1);
  localparam logic [CW:0] ACT_C  = (CW+1)'(ACTIVE_COLS);
  localparam logic [RW:0] ACT_R  = (RW+1)'(ACTIVE_ROWS);
  localparam logic [CW:0] HS_BEG = (CW+1)'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [CW:0] HS_END =
    (CW+1)'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [RW:0] VS_BEG = (RW+1)'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [RW:0] VS_END =
    (RW+1)'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

  if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) begin : g_bad_h
    $error("vga_sync_gen: horizontal timing exceeds TOTAL_COLS");
  end
  if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) begin : g_bad_v
    $error("vga_sync_gen: vertical timing exceeds TOTAL_ROWS");
  end
  if (SYNC_DELAY < 1) begin : g_bad_d
    $error("vga_sync_gen: SYNC_DELAY must be at least 1");
  end

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_hs;
  logic          r_vs;
  logic          r_act;
  logic          r_fs;

  logic [CW-1:0] w_col_nxt;
  logic [RW-1:0] w_row_nxt;
  logic [CW:0]   w_col_x;
  logic [RW:0]   w_row_x;
  logic          w_hs_nxt;
  logic          w_vs_nxt;
  logic          w_act_nxt;
  logic          w_fs_nxt;

  // Next position and the flags that describe it.
  always_comb begin
    w_col_nxt = r_col + CW'(1);
    w_row_nxt = r_row;
    if (r_col == COL_MAX) begin
      w_col_nxt = '0;
      w_row_nxt = (r_row == ROW_MAX) ? '0 : r_row + RW'(1);
    end
    w_col_x   = {1'b0, w_col_nxt};
    w_row_x   = {1'b0, w_row_nxt};
    w_hs_nxt  = !((w_col_x >= HS_BEG) && (w_col_x < HS_END));
    w_vs_nxt  = !((w_row_x >= VS_BEG) && (w_row_x < VS_END));
    w_act_nxt = (w_col_x < ACT_C) && (w_row_x < ACT_R);
    w_fs_nxt  = (w_col_nxt == '0) && (w_row_nxt == '0);
  end

  // Position and flags advance together on enabled steps.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_act <= 1'b0;
      r_fs  <= 1'b0;
    end else if (i_pix_en) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
      r_hs  <= w_hs_nxt;
      r_vs  <= w_vs_nxt;
      r_act <= w_act_nxt;
      r_fs  <= w_fs_nxt;
    end else begin
      r_fs  <= 1'b0;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] r_hs_dly;
  logic [SYNC_DELAY-1:0] r_vs_dly;

  // Sync shift registers so syncs line up with the downstream pixel pipe.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hs_dly <= '1;
      r_vs_dly <= '1;
    end else if (i_pix_en) begin
      r_hs_dly[0] <= r_hs;
      r_vs_dly[0] <= r_vs;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        r_hs_dly[i] <= r_hs_dly[i-1];
        r_vs_dly[i] <= r_vs_dly[i-1];
      end
    end
  end

  assign o_hsync = r_hs_dly[SYNC_DELAY-1];
  assign o_vsync = r_vs_dly[SYNC_DELAY-1];
`else
  assign o_hsync = r_hs;
  assign o_vsync = r_vs;
`endif

  assign o_col         = r_col;
  assign o_row         = r_row;
  assign o_active      = r_act;
  assign o_frame_start = r_fs;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default 640x480 timing
// plus a tiny 10x8 instance for frame-level behaviour.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;

  logic       hs, vs, act, fs;
  logic [9:0] col;
  logic [9:0] row;

  logic       s_hs, s_vs, s_act, s_fs;
  logic [3:0] s_col;
  logic [2:0] s_row;

  int n_chk  = 0;
  int n_fail = 0;

  int hs_n, hs_lo, hs_hi, act_n, act_bad;
  int row_chg, chg_col, prev_row, prev_col, c0;
  int fs_n, fs1, fs2, fs_bad, fs_dbl, prev_fs;
  int vs_n, vs_lo, vs_hi, wrap_n, w1, w2;

  vga_sync_gen u_dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .i_pix_en      (pix_en),
    .o_hsync       (hs),
    .o_vsync       (vs),
    .o_col         (col),
    .o_row         (row),
    .o_active      (act),
    .o_frame_start (fs)
  );

  vga_sync_gen #(
    .TOTAL_COLS    (10),
    .TOTAL_ROWS    (8),
    .ACTIVE_COLS   (6),
    .ACTIVE_ROWS   (5),
    .H_FRONT_PORCH (1),
    .H_SYNC_WIDTH  (2),
    .V_FRONT_PORCH (1),
    .V_SYNC_WIDTH  (2)
  ) u_small (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .i_pix_en      (pix_en),
    .o_hsync       (s_hs),
    .o_vsync       (s_vs),
    .o_col         (s_col),
    .o_row         (s_row),
    .o_active      (s_act),
    .o_frame_start (s_fs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    pix_en = 1'b1;
    repeat (3) step;
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_hs", hs, 1);
    chk("rst_vs", vs, 1);
    chk("rst_act", act, 0);
    chk("rst_fs", fs, 0);
    chk("rst_scol", s_col, 0);

    rst_n = 1'b1;
    step;
    chk("start_col1", col, 1);
    chk("start_act", act, 1);
    chk("start_fs", fs, 0);
    step;
    chk("start_col2", col, 2);
    step;
    chk("start_col3", col, 3);

    // One full line on the default timing
    hs_n = 0; hs_lo = 9999; hs_hi = -1; act_n = 0; act_bad = 0;
    row_chg = 0; chg_col = -1; prev_row = int'(row);
    for (int i = 0; i < 800; i++) begin
      step;
      if (!hs) begin
        hs_n++;
        if (int'(col) < hs_lo) hs_lo = int'(col);
        if (int'(col) > hs_hi) hs_hi = int'(col);
      end
      if (act) act_n++;
      if (act && col >= 10'd640) act_bad++;
      if (int'(row) != prev_row) begin
        row_chg++;
        chg_col  = int'(col);
        prev_row = int'(row);
      end
    end
    chk("line_hs_cnt", hs_n, 96);
    chk("line_hs_first", hs_lo, 656);
    chk("line_hs_last", hs_hi, 751);
    chk("line_act_cnt", act_n, 640);
    chk("line_act_blank", act_bad, 0);
    chk("line_row_chg", row_chg, 1);
    chk("line_row_chg_col", chg_col, 0);
    chk("line_end_col", col, 3);
    chk("line_end_row", row, 1);

    // Enable toggling: counters advance every second clock
    c0 = int'(col);
    for (int i = 0; i < 8; i++) begin
      pix_en = (i % 2 == 0);
      step;
    end
    chk("tog_col", col, c0 + 4);
    pix_en = 1'b0;
    step;
    chk("hold_col", col, c0 + 4);
    chk("hold_fs", fs, 0);
    pix_en = 1'b1;

    // Mid-line asynchronous reset inside the hsync pulse
    for (int i = 0; i < 1000; i++) begin
      if (col == 10'd700) break;
      step;
    end
    chk("seek_col700", col, 700);
    chk("seek_hs_low", hs, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_col", col, 0);
    chk("arst_row", row, 0);
    chk("arst_hs", hs, 1);
    chk("arst_act", act, 0);
    step;
    step;
    rst_n = 1'b1;

    // Two full frames on the 10x8 instance
    fs_n = 0; fs1 = -1; fs2 = -1; fs_bad = 0;
    vs_n = 0; vs_lo = 99; vs_hi = -1; hs_n = 0; act_n = 0;
    wrap_n = 0; prev_col = int'(s_col);
    for (int k = 1; k <= 160; k++) begin
      step;
      if (s_fs) begin
        fs_n++;
        if (fs1 < 0) fs1 = k;
        else fs2 = k;
        if (s_col != 4'd0 || s_row != 3'd0) fs_bad++;
      end
      if (!s_vs) begin
        vs_n++;
        if (int'(s_row) < vs_lo) vs_lo = int'(s_row);
        if (int'(s_row) > vs_hi) vs_hi = int'(s_row);
      end
      if (!s_hs) hs_n++;
      if (s_act) act_n++;
      if (prev_col == 9 && s_col == 4'd0) wrap_n++;
      prev_col = int'(s_col);
    end
    chk("sm_fs_cnt", fs_n, 2);
    chk("sm_fs_first", fs1, 80);
    chk("sm_fs_second", fs2, 160);
    chk("sm_fs_pos", fs_bad, 0);
    chk("sm_vs_cnt", vs_n, 40);
    chk("sm_vs_first", vs_lo, 6);
    chk("sm_vs_last", vs_hi, 7);
    chk("sm_hs_cnt", hs_n, 32);
    chk("sm_act_cnt", act_n, 60);
    chk("sm_col_wrap", wrap_n, 16);

    // Toggled enable on the small instance: two frames over 320 clocks
    fs_n = 0; fs_dbl = 0; prev_fs = 0; w1 = -1; w2 = -1;
    prev_col = int'(s_col);
    for (int i = 0; i < 320; i++) begin
      pix_en = (i % 2 == 0);
      step;
      if (s_fs) begin
        fs_n++;
        if (prev_fs != 0) fs_dbl++;
      end
      prev_fs = int'(s_fs);
      if (prev_col == 9 && s_col == 4'd0) begin
        if (w1 < 0) w1 = i;
        else if (w2 < 0) w2 = i;
      end
      prev_col = int'(s_col);
    end
    pix_en = 1'b1;
    chk("tog_fs_cnt", fs_n, 2);
    chk("tog_fs_width", fs_dbl, 0);
    chk("tog_line_first", w1, 18);
    chk("tog_line_period", w2 - w1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
